// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
//   Shared word/PC definitions for the instruction-fetch front end.
//   Provides the global fetch defines, the buffer entry layout and small
//   PC helper functions used by ifetch_buf and ifetch_unit.
//   Ports: none (package).
// ---------------------------------------------------------------------------
`ifndef IFETCH_DEFINES_SVH
`define IFETCH_DEFINES_SVH
`define WORD_WIDTH 32
`define INST_BYTES 32'd4
`define RESET_PC_DEFAULT 32'h0000_0000
`endif

package ifetch_pkg;

  localparam int unsigned WORD_W = `WORD_WIDTH;
  localparam logic [WORD_W-1:0] INST_BYTES = `INST_BYTES;

  // One buffered instruction: its PC in the upper half, the word below.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] code;
  } ibuf_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

  // Sequential successor of a fetch PC (wraps mod 2^32).
  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// ---------------------------------------------------------------------------
// ifetch_buf
//   Synchronous FIFO holding fetched {pc, code} entries until decode takes them.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     push, wdata     enqueue one entry
//     pop, rdata      dequeue head (rdata shows the head)
//     flush           discard all entries (wins over push/pop)
//     empty, full     status
//     count           current occupancy
// ---------------------------------------------------------------------------
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  ibuf_entry_t   wdata,
  output ibuf_entry_t   rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  ibuf_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer and occupancy values; a flush returns to the empty state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a push in a flush cycle belongs to the discarded path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == {CW{1'b0}});
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   MIPS instruction-fetch front end. Issues word reads to instruction memory
//   under a credit limit, buffers in-order responses with their PC, and hands
//   them to decode. A redirect restarts fetch and drops wrong-path work.
//   Ports:
//     clk, rst_n                         clock, async active-low reset
//     redirect_valid, redirect_pc        new fetch target (bits[1:0] ignored)
//     imem_req_valid/ready/addr          fetch request channel
//     imem_rsp_valid/data                in-order read responses
//     inst_valid/ready, inst_code,
//     inst_pc, inst_pc4                  instruction channel toward decode
// ---------------------------------------------------------------------------
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = `RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] buf_count;
  logic          buf_empty;
  logic          buf_full;
  logic          buf_push;
  logic          buf_pop;
  ibuf_entry_t   buf_wdata;
  ibuf_entry_t   buf_rdata;

  logic [CW:0]   credit_used;
  logic          req_valid;
  logic          req_accept;
  logic          head_valid;

  // Credit and handshake decode. Only registered counts feed the credit so a
  // pop in this cycle never frees a slot until the next one.
  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, buf_count};
    req_valid   = rst_n && !redirect_valid && (credit_used < (CW+1)'(BUF_DEPTH));
    req_accept  = req_valid && imem_req_ready;
    head_valid  = rst_n && !buf_empty && !redirect_valid;
    buf_pop     = head_valid && inst_ready;
    // Responses are kept only on the current path with nothing left to drop.
    buf_push    = imem_rsp_valid && !redirect_valid && (drop_cnt_q == {CW{1'b0}});
    buf_wdata   = '{pc: rsp_pc_q, code: imem_rsp_data};
  end

  // Next-state for the PCs and counters; a redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    case ({req_accept, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      // Everything still in flight after this cycle is wrong-path.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_accept) begin
        fetch_pc_d = next_pc(fetch_pc_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (buf_push) begin
        rsp_pc_d = next_pc(rsp_pc_q);
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      if (imem_rsp_valid && (drop_cnt_q != {CW{1'b0}})) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  ifetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .wdata (buf_wdata),
    .rdata (buf_rdata),
    .empty (buf_empty),
    .full  (buf_full),
    .count (buf_count)
  );

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = head_valid;
  // Decode-side data is forced to zero while reset is held.
  assign inst_code      = rst_n ? buf_rdata.code : 32'h0000_0000;
  assign inst_pc        = rst_n ? buf_rdata.pc : 32'h0000_0000;
  assign inst_pc4       = rst_n ? next_pc(buf_rdata.pc) : 32'h0000_0000;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//   Randomized bench for ifetch_unit. A transaction-level reference keeps the
//   in-flight requests (tagged with a path epoch) and the expected decode
//   queue; every cycle the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  ifetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        imem_q[$];   // accepted requests awaiting a response
  logic [31:0] dec_q[$];    // PCs expected at decode, in order
  logic [31:0] m_fetch_pc;
  int          epoch, cyc, last_due;
  int          n_tests, n_fail, n_acc;
  int          first_acc, first_iv;
  int          p_rr, p_ir, p_rd, lat_max;
  bit          force_rd;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    #1;
    chk_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk_eq("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk_eq("rst_inst_code", inst_code, 32'h0);
    chk_eq("rst_inst_pc", inst_pc, 32'h0);
    chk_eq("rst_inst_pc4", inst_pc4, 32'h0);
    imem_q.delete();
    dec_q.delete();
    m_fetch_pc = RST_PC;
    epoch++;
    last_due = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle();
    bit   rd, rsp, want_rv, want_iv;
    req_t r;
    int   due;
    @(negedge clk);
    cyc++;
    rd             = force_rd || ($urandom_range(0, 99) < p_rd);
    redirect_valid = rd;
    redirect_pc    = force_rd ? force_pc : 32'($urandom_range(0, 1023));
    force_rd       = 1'b0;
    imem_req_ready = ($urandom_range(0, 99) < p_rr);
    inst_ready     = ($urandom_range(0, 99) < p_ir);
    rsp            = (imem_q.size() > 0) && (imem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(imem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    want_rv = !rd && ((imem_q.size() + dec_q.size()) < DEPTH);
    want_iv = !rd && (dec_q.size() > 0);
    chk_eq("req_valid", {31'h0, imem_req_valid}, {31'h0, want_rv});
    chk_eq("req_addr", imem_req_addr, m_fetch_pc);
    chk_eq("inst_valid", {31'h0, inst_valid}, {31'h0, want_iv});
    chk_eq("push_when_full", {31'h0, u_dut.buf_push && u_dut.buf_full}, 32'h0);
    if (want_iv) begin
      chk_eq("inst_pc", inst_pc, dec_q[0]);
      chk_eq("inst_code", inst_code, mem_word(dec_q[0]));
      chk_eq("inst_pc4", inst_pc4, dec_q[0] + 32'd4);
    end
    if (first_iv < 0 && inst_valid) first_iv = cyc;
    // Reference update for the coming clock edge.
    if (rsp) begin
      r = imem_q.pop_front();
      if (r.epoch == epoch && !rd) dec_q.push_back(r.addr);
    end
    if (rd) begin
      epoch++;
      dec_q.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (want_iv && inst_ready) void'(dec_q.pop_front());
      if (want_rv && imem_req_ready) begin
        due = cyc + $urandom_range(1, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        imem_q.push_back('{addr: m_fetch_pc, epoch: epoch, due: due});
        m_fetch_pc = m_fetch_pc + 32'd4;
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    inst_ready = 1'b0;
    epoch = 0; cyc = 0; last_due = 0; n_tests = 0; n_fail = 0; n_acc = 0;
    first_acc = -1; first_iv = -1; force_rd = 1'b0; force_pc = 32'h0;
    m_fetch_pc = RST_PC;

    // Streaming with a 1-cycle memory and an always-ready decoder.
    p_rr = 100; p_ir = 100; p_rd = 0; lat_max = 1;
    do_reset();
    repeat (20) cycle();
    chk_eq("first_latency", 32'(first_iv - first_acc), 32'd2);

    // Decoder stalled: the credit limit stops fetch after four requests.
    do_reset();
    p_ir = 0; n_acc = 0;
    repeat (10) cycle();
    chk_eq("stall_accepts", 32'(n_acc), 32'd4);
    p_ir = 100;
    repeat (10) cycle();

    // Random backpressure, variable latency and redirects.
    p_rr = 70; p_ir = 70; p_rd = 6; lat_max = 3;
    repeat (600) cycle();

    // Misaligned redirect target.
    p_rd = 0; force_rd = 1'b1; force_pc = 32'h0000_0043;
    repeat (8) cycle();

    // Reset in the middle of traffic, then resume.
    do_reset();
    p_rr = 80; p_ir = 80; p_rd = 5; lat_max = 2;
    repeat (300) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
